// File: rtl/srio_pkg.sv
// Shared SRIO logical-layer widths, ftype codes and ireq arbiter types.
package srio_pkg;

    localparam int SRIO_DATA_W = 64;
    localparam int SRIO_KEEP_W = 8;
    localparam int SRIO_USER_W = 32;

    localparam logic [3:0] FTYPE_DOORB = 4'hA;
    localparam logic [3:0] FTYPE_NWR   = 4'h5;

    typedef enum logic {
        IDLE,
        XFER
    } arb_state_e;

    typedef struct packed {
        logic [SRIO_DATA_W-1:0] tdata;
        logic [SRIO_KEEP_W-1:0] tkeep;
        logic                   tlast;
        logic [SRIO_USER_W-1:0] tuser;
    } ireq_beat_t;

endpackage

// File: rtl/ireq_skid.sv
// Two-entry register slice for ireq beats; entry 0 is always the head.
module ireq_skid
    import srio_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  ireq_beat_t i_beat,
    input  logic       i_pop,
    output ireq_beat_t o_head,
    output logic [1:0] o_count
);

    ireq_beat_t r_e0;
    ireq_beat_t r_e1;
    logic [1:0] r_count;
    logic       w_pop;
    logic       w_push;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= i_beat;
                    else                 r_e1 <= i_beat;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_e0 <= i_beat;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_e0;
    assign o_count = r_count;

endmodule

// File: rtl/ireq_arb.sv
// Packet-locked round-robin arbiter sharing the SRIO ireq channel between
// up to four initiators, with a register slice toward the core.
module ireq_arb
    import srio_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BURST_PKTS = 4
) (
    input  logic                           log_clk,
    input  logic                           log_rst_n,
    input  logic [NUM_REQ-1:0]             s_tvalid,
    output logic [NUM_REQ-1:0]             s_tready,
    input  logic [NUM_REQ*SRIO_DATA_W-1:0] s_tdata,
    input  logic [NUM_REQ*SRIO_KEEP_W-1:0] s_tkeep,
    input  logic [NUM_REQ-1:0]             s_tlast,
    input  logic [NUM_REQ*SRIO_USER_W-1:0] s_tuser,
    output logic                           ireq_tvalid_o,
    input  logic                           ireq_tready_in,
    output logic                           ireq_tlast_o,
    output logic [SRIO_DATA_W-1:0]         ireq_tdata_o,
    output logic [SRIO_KEEP_W-1:0]         ireq_tkeep_o,
    output logic [SRIO_USER_W-1:0]         ireq_tuser_o,
    output logic [NUM_REQ-1:0]             grant_o,
    output logic                           busy_o
);

    localparam int IW = 2;

    arb_state_e         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [IW-1:0]      r_last, w_last_nxt;
    logic [3:0]         r_pkt_cnt, w_pkt_cnt_nxt;
    logic               r_bnd, w_bnd_nxt;

    logic [IW-1:0]      w_pick;
    logic               w_pick_vld;
    logic [IW-1:0]      w_gidx;
    ireq_beat_t         w_beat;
    ireq_beat_t         w_head;
    logic [1:0]         w_count;
    logic [NUM_REQ-1:0] w_acc_vec;
    logic               w_acc;
    logic               w_acc_last;
    logic               w_gvalid;
    logic               w_other;

    function automatic int wrap_idx(input int a);
        return (a >= NUM_REQ) ? a - NUM_REQ : a;
    endfunction

    // Ready comes only from registered grant and slice occupancy.
    assign s_tready   = r_grant & {NUM_REQ{w_count != 2'd2}};
    assign w_acc_vec  = s_tvalid & s_tready;
    assign w_acc      = |w_acc_vec;
    assign w_acc_last = |(w_acc_vec & s_tlast);
    assign w_gvalid   = |(s_tvalid & r_grant);
    assign w_other    = |(s_tvalid & ~r_grant);

    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_pick_vld && s_tvalid[j] &&
                    (j == wrap_idx(int'(r_last) + k))) begin
                    w_pick_vld = 1'b1;
                    w_pick     = IW'(j);
                end
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        w_beat = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant[j]) begin
                w_gidx       = IW'(j);
                w_beat.tdata = s_tdata[j*SRIO_DATA_W +: SRIO_DATA_W];
                w_beat.tkeep = s_tkeep[j*SRIO_KEEP_W +: SRIO_KEEP_W];
                w_beat.tlast = s_tlast[j];
                w_beat.tuser = s_tuser[j*SRIO_USER_W +: SRIO_USER_W];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        w_pkt_cnt_nxt = r_pkt_cnt;
        w_bnd_nxt     = r_bnd;
        unique case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt   = XFER;
                    w_grant_nxt   = NUM_REQ'(1) << w_pick;
                    w_pkt_cnt_nxt = '0;
                    w_bnd_nxt     = 1'b1;
                end
            end
            XFER: begin
                if (w_acc && w_acc_last) begin
                    if (r_pkt_cnt + 4'd1 == 4'(BURST_PKTS)) begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_last_nxt  = w_gidx;
                    end else begin
                        w_pkt_cnt_nxt = r_pkt_cnt + 4'd1;
                        w_bnd_nxt     = 1'b1;
                    end
                end else if (w_acc) begin
                    w_bnd_nxt = 1'b0;
                end else if (r_bnd && !w_gvalid && w_other) begin
                    // Idle owner at a packet edge yields to a waiting source.
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = w_gidx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_last    <= IW'(NUM_REQ - 1);
            r_pkt_cnt <= '0;
            r_bnd     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_pkt_cnt <= w_pkt_cnt_nxt;
            r_bnd     <= w_bnd_nxt;
        end
    end

    ireq_skid u_skid (
        .i_clk   (log_clk),
        .i_rst_n (log_rst_n),
        .i_push  (w_acc),
        .i_beat  (w_beat),
        .i_pop   (ireq_tready_in),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign ireq_tvalid_o = (w_count != 2'd0);
    assign ireq_tlast_o  = w_head.tlast;
    assign ireq_tdata_o  = w_head.tdata;
    assign ireq_tkeep_o  = w_head.tkeep;
    assign ireq_tuser_o  = w_head.tuser;
    assign grant_o       = r_grant;
    assign busy_o        = (r_state != IDLE) || (w_count != 2'd0);

endmodule
